fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- single-issue instruction fetch stage.
//
// Presents a fetch address to a registered instruction memory and forwards
// the returning word to decode one cycle later. One instruction per clock in
// steady state, a single bubble after reset release and after each redirect.
//
// Ports:
//   clk            in   1   clock, rising-edge active
//   reset          in   1   asynchronous, active-high reset
//   stall          in   1   decode-stage hold request
//   redirect       in   1   taken branch/jump, one cycle wide (wins over stall)
//   redirect_addr  in   6   branch/jump target, valid while redirect=1
//   instruction    in  32   memory read data for the Addr of the previous cycle
//   Addr           out  6   memory read address (combinational)
//   inst_out       out 32   registered instruction to decode
//   pc_out         out  6   address of inst_out
//   inst_valid     out  1   inst_out holds a real fetched word
//   fetch_count    out 16   valid instructions delivered, saturating
//
// Handshake: there is no ready/valid pair on the memory side. A word requested
// via Addr in cycle N is on instruction in cycle N+1. inst_valid qualifies
// inst_out for every cycle it is high; decode holds the stage with stall, and
// while stalled the outputs do not change.
module fetch_unit #(
    parameter logic [31:0] NOP_WORD = 32'h0007_8000,
    parameter logic [5:0]  RESET_PC = 6'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [5:0]  redirect_addr,
    input  logic [31:0] instruction,
    output logic [5:0]  Addr,
    output logic [31:0] inst_out,
    output logic [5:0]  pc_out,
    output logic        inst_valid,
    output logic [15:0] fetch_count
);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0] state;
    logic [5:0] pc;        // next address to request
    logic [5:0] fetch_pc;  // address of the word currently returning

    // While stalled in RUN the in-flight address is re-issued so the memory
    // keeps presenting the same word; a redirect always takes priority.
    always_comb begin
        Addr = pc;
        if (redirect) begin
            Addr = redirect_addr;
        end else if (state == ST_RUN && stall) begin
            Addr = fetch_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_FILL;
            pc          <= RESET_PC;
            fetch_pc    <= RESET_PC;
            inst_out    <= NOP_WORD;
            pc_out      <= RESET_PC;
            inst_valid  <= 1'b0;
            fetch_count <= 16'd0;
        end else if (redirect) begin
            // The word arriving now belongs to the wrong path: squash it.
            // Target is requested this cycle, so it reaches inst_out next edge.
            state      <= ST_RUN;
            inst_out   <= NOP_WORD;
            inst_valid <= 1'b0;
            fetch_pc   <= redirect_addr;
            pc         <= redirect_addr + 6'd1;
        end else if (state == ST_FILL) begin
            // Memory output is stale right after reset; emit a bubble.
            state      <= ST_RUN;
            inst_out   <= NOP_WORD;
            inst_valid <= 1'b0;
            fetch_pc   <= pc;
            pc         <= pc + 6'd1;
        end else if (!stall) begin
            inst_out   <= instruction;
            pc_out     <= fetch_pc;
            inst_valid <= 1'b1;
            fetch_pc   <= pc;
            pc         <= pc + 6'd1;
            if (fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed and randomized checks of fetch_unit against a
// stream-level reference model (bubble pending flag + next address to deliver).
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0007_8000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [5:0]  redirect_addr;
    logic [31:0] instruction;
    logic [5:0]  Addr;
    logic [31:0] inst_out;
    logic [5:0]  pc_out;
    logic        inst_valid;
    logic [15:0] fetch_count;

    int tests;
    int fails;

    // reference model state
    bit          m_bubble;   // next edge emits a start-up bubble
    logic [5:0]  m_next;     // address of the next word to be delivered
    logic [31:0] m_inst;
    logic [5:0]  m_pc_out;
    logic        m_valid;
    int          m_count;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instruction   (instruction),
        .Addr          (Addr),
        .inst_out      (inst_out),
        .pc_out        (pc_out),
        .inst_valid    (inst_valid),
        .fetch_count   (fetch_count)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // registered ROM: mem[k] = A000_0000 | k
    always @(posedge clk) instruction <= 32'hA000_0000 | {26'd0, Addr};

    function automatic logic [31:0] rom(input logic [5:0] a);
        return 32'hA000_0000 | {26'd0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bubble = 1'b1;
        m_next   = 6'd0;
        m_inst   = NOP;
        m_pc_out = 6'd0;
        m_valid  = 1'b0;
        m_count  = 0;
    endtask

    // Address the stage is requesting: the redirect target, otherwise the word
    // still owed to decode (bubble pending or stalled), otherwise the one after it.
    function automatic logic [5:0] model_addr(input logic s, input logic r, input logic [5:0] ra);
        if (r) return ra;
        if (m_bubble || s) return m_next;
        return m_next + 6'd1;
    endfunction

    task automatic model_edge(input logic s, input logic r, input logic [5:0] ra);
        if (r) begin
            m_inst   = NOP;
            m_valid  = 1'b0;
            m_next   = ra;
            m_bubble = 1'b0;
        end else if (m_bubble) begin
            m_inst   = NOP;
            m_valid  = 1'b0;
            m_bubble = 1'b0;
        end else if (!s) begin
            m_inst   = rom(m_next);
            m_pc_out = m_next;
            m_valid  = 1'b1;
            m_next   = m_next + 6'd1;
            if (m_count < 65535) m_count++;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".inst_out"},    inst_out,            m_inst);
        chk({tag, ".pc_out"},      {26'd0, pc_out},     {26'd0, m_pc_out});
        chk({tag, ".inst_valid"},  {31'd0, inst_valid}, {31'd0, m_valid});
        chk({tag, ".fetch_count"}, {16'd0, fetch_count}, 32'(m_count));
    endtask

    // driver: one clock cycle, entered and left just after a falling edge
    task automatic cycle(input logic s, input logic r, input logic [5:0] ra);
        stall         = s;
        redirect      = r;
        redirect_addr = ra;
        #1;
        chk("addr", {26'd0, Addr}, {26'd0, model_addr(s, r, ra)});
        @(posedge clk);
        model_edge(s, r, ra);
        #1;
        check_outputs("edge");
        @(negedge clk);
    endtask

    task automatic run_until_pc(input logic [5:0] target);
        int budget;
        budget = 200;
        while (!(inst_valid && pc_out == target) && budget > 0) begin
            cycle(1'b0, 1'b0, 6'd0);
            budget--;
        end
        chk("run_until_budget", {31'd0, budget > 0}, 32'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_addr = 6'd0;
        model_reset();
        #2;
        check_outputs("reset");
        chk("reset.addr", {26'd0, Addr}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // start-up: bubble, then 0, 1
        cycle(1'b0, 1'b0, 6'd0);
        chk("fill.valid", {31'd0, inst_valid}, 32'd0);
        cycle(1'b0, 1'b0, 6'd0);
        chk("first.inst", inst_out, 32'hA000_0000);
        cycle(1'b0, 1'b0, 6'd0);
        chk("second.inst", inst_out, 32'hA000_0001);
        chk("second.count", {16'd0, fetch_count}, 32'd2);

        // stall three cycles holding pc_out=4
        run_until_pc(6'd4);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 6'd0);
            chk("stall.inst", inst_out, 32'hA000_0004);
            chk("stall.addr", {26'd0, Addr}, 32'd5);
        end
        cycle(1'b0, 1'b0, 6'd0);
        chk("unstall.pc5", {26'd0, pc_out}, 32'd5);
        cycle(1'b0, 1'b0, 6'd0);
        chk("unstall.pc6", {26'd0, pc_out}, 32'd6);

        // redirect to 40 while pc_out=10
        run_until_pc(6'd10);
        cycle(1'b0, 1'b1, 6'd40);
        chk("redir.bubble", inst_out, 32'h0007_8000);
        cycle(1'b0, 1'b0, 6'd0);
        chk("redir.target", inst_out, 32'hA000_0028);
        cycle(1'b0, 1'b0, 6'd0);
        chk("redir.next", {26'd0, pc_out}, 32'd41);

        // redirect wins over stall
        cycle(1'b1, 1'b1, 6'd20);
        cycle(1'b1, 1'b0, 6'd0);
        cycle(1'b0, 1'b0, 6'd0);
        chk("redir_stall.pc", {26'd0, pc_out}, 32'd20);

        // wrap 63 -> 0
        cycle(1'b0, 1'b1, 6'd63);
        cycle(1'b0, 1'b0, 6'd0);
        chk("wrap.pc63", {26'd0, pc_out}, 32'd63);
        cycle(1'b0, 1'b0, 6'd0);
        chk("wrap.pc0", {26'd0, pc_out}, 32'd0);
        cycle(1'b0, 1'b0, 6'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                  6'($urandom_range(0, 63)));
        end

        // asynchronous reset in the middle of a stall at pc_out=20
        cycle(1'b0, 1'b1, 6'd19);
        cycle(1'b0, 1'b0, 6'd0);
        cycle(1'b0, 1'b0, 6'd0);
        chk("pre_reset.pc", {26'd0, pc_out}, 32'd20);
        cycle(1'b1, 1'b0, 6'd0);
        stall = 1'b1;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs("async_reset");
        chk("async_reset.addr", {26'd0, Addr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 6'd0);
        chk("restart.count", {16'd0, fetch_count}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
